// File: rtl/vc_scheduler.sv
// Weighted round-robin scheduler for two virtual-channel FIFOs feeding two destination FIFOs.
// Bursts of up to W0/W1 pops per turn; back-pressure from the head word's destination suppresses pops.
module vc_scheduler #(
   parameter int W0    = 3,
   parameter int W1    = 1,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       active_in,
   input  logic       vc0_empty,
   input  logic       vc1_empty,
   input  logic       vc0_dest,
   input  logic       vc1_dest,
   input  logic       pause_d0,
   input  logic       pause_d1,
   output logic       pop_vc0,
   output logic       pop_vc1,
   output logic       valid_vc0,
   output logic       valid_vc1,
   output logic       sel_vc,
   output logic [7:0] grants0,
   output logic [7:0] grants1
);

   // A zero weight still gets one grant per turn.
   localparam int Q0 = (W0 == 0) ? 1 : W0;
   localparam int Q1 = (W1 == 0) ? 1 : W1;
   localparam logic [CNT_W-1:0] LAST0 = CNT_W'(Q0 - 1);
   localparam logic [CNT_W-1:0] LAST1 = CNT_W'(Q1 - 1);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_served;
   logic             elig0;
   logic             elig1;

   assign elig0 = active_in & ~vc0_empty & ~(vc0_dest ? pause_d1 : pause_d0);
   assign elig1 = active_in & ~vc1_empty & ~(vc1_dest ? pause_d1 : pause_d0);

   // Pops are combinational so a burst or a VC switch never loses a cycle.
   assign pop_vc0 = ~reset & (state == GRANT0) & elig0;
   assign pop_vc1 = ~reset & (state == GRANT1) & elig1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         last_served <= 1'b1;
         sel_vc      <= 1'b0;
         valid_vc0   <= 1'b0;
         valid_vc1   <= 1'b0;
         grants0     <= 8'd0;
         grants1     <= 8'd0;
      end else begin
         // Read data appears one cycle after the pop.
         valid_vc0 <= pop_vc0;
         valid_vc1 <= pop_vc1;
         if (pop_vc0)
            sel_vc <= 1'b0;
         else if (pop_vc1)
            sel_vc <= 1'b1;
         if (pop_vc0)
            grants0 <= grants0 + 8'd1;
         if (pop_vc1)
            grants1 <= grants1 + 8'd1;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (elig0 && elig1)
                  state <= last_served ? GRANT0 : GRANT1;
               else if (elig0)
                  state <= GRANT0;
               else if (elig1)
                  state <= GRANT1;
               else
                  state <= IDLE;
            end
            GRANT0: begin
               if (pop_vc0) begin
                  if (cnt != LAST0) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     cnt         <= '0;
                     last_served <= 1'b0;
                     if (elig1)
                        state <= GRANT1;
                  end
               end else begin
                  cnt         <= '0;
                  last_served <= 1'b0;
                  state       <= elig1 ? GRANT1 : IDLE;
               end
            end
            GRANT1: begin
               if (pop_vc1) begin
                  if (cnt != LAST1) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     cnt         <= '0;
                     last_served <= 1'b1;
                     if (elig0)
                        state <= GRANT0;
                  end
               end else begin
                  cnt         <= '0;
                  last_served <= 1'b1;
                  state       <= elig0 ? GRANT0 : IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vc_scheduler.sv
// Directed bench for vc_scheduler: behavioural FIFO occupancy model plus hand-computed pop patterns.
module tb_vc_scheduler;

   logic       clk;
   logic       reset;
   logic       active_in;
   logic       vc0_empty;
   logic       vc1_empty;
   logic       vc0_dest;
   logic       vc1_dest;
   logic       pause_d0;
   logic       pause_d1;
   logic       pop_vc0;
   logic       pop_vc1;
   logic       valid_vc0;
   logic       valid_vc1;
   logic       sel_vc;
   logic [7:0] grants0;
   logic [7:0] grants1;

   int occ0;
   int occ1;
   int n_cmp;
   int n_fail;

   assign vc0_empty = (occ0 == 0);
   assign vc1_empty = (occ1 == 0);

   vc_scheduler #(.W0(3), .W1(1), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .active_in (active_in),
      .vc0_empty (vc0_empty),
      .vc1_empty (vc1_empty),
      .vc0_dest  (vc0_dest),
      .vc1_dest  (vc1_dest),
      .pause_d0  (pause_d0),
      .pause_d1  (pause_d1),
      .pop_vc0   (pop_vc0),
      .pop_vc1   (pop_vc1),
      .valid_vc0 (valid_vc0),
      .valid_vc1 (valid_vc1),
      .sel_vc    (sel_vc),
      .grants0   (grants0),
      .grants1   (grants1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called just after a falling edge: sample pops, clock, then drain the modelled FIFOs.
   task automatic tick(output logic p0, output logic p1);
      #1;
      p0 = pop_vc0;
      p1 = pop_vc1;
      @(posedge clk);
      #1;
      if (p0 && occ0 > 0) occ0--;
      if (p1 && occ1 > 0) occ1--;
      @(negedge clk);
   endtask

   task automatic do_reset();
      logic p0, p1;
      reset     = 1'b1;
      active_in = 1'b0;
      occ0      = 0;
      occ1      = 0;
      vc0_dest  = 1'b0;
      vc1_dest  = 1'b0;
      pause_d0  = 1'b0;
      pause_d1  = 1'b0;
      tick(p0, p1);
      tick(p0, p1);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic p0, p1;
      reset     = 1'b1;
      active_in = 1'b1;
      occ0      = 4;
      occ1      = 4;
      vc0_dest  = 1'b0;
      vc1_dest  = 1'b0;
      pause_d0  = 1'b0;
      pause_d1  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(p0, p1);
         n_cmp++;
         if ({p1, p0} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pops cycle %0d: got %b, want 00", i, {p1, p0});
         end
      end
      n_cmp++;
      if ({valid_vc1, valid_vc0, sel_vc, grants0, grants1} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b%b sel=%b g0=%0d g1=%0d, want all 0",
                  valid_vc1, valid_vc0, sel_vc, grants0, grants1);
      end
   endtask

   task automatic test_round_robin();
      logic p0, p1;
      int   exp[11] = '{0, 1, 1, 1, 2, 1, 1, 1, 2, 1, 1};
      logic [1:0] e;
      do_reset();
      occ0      = 8;
      occ1      = 8;
      active_in = 1'b1;
      for (int i = 0; i < 11; i++) begin
         e = 2'(exp[i]);
         tick(p0, p1);
         n_cmp++;
         if ({p1, p0} !== e) begin
            n_fail++;
            $display("FAIL rr_pop cycle %0d: got %b, want %b", i, {p1, p0}, e);
         end
         n_cmp++;
         if ({valid_vc1, valid_vc0} !== e) begin
            n_fail++;
            $display("FAIL rr_valid cycle %0d: got %b, want %b", i, {valid_vc1, valid_vc0}, e);
         end
         if (e != 2'b00) begin
            n_cmp++;
            if (sel_vc !== e[1]) begin
               n_fail++;
               $display("FAIL rr_sel cycle %0d: got %b, want %b", i, sel_vc, e[1]);
            end
         end
      end
      n_cmp++;
      if (grants0 !== 8'd8 || grants1 !== 8'd2) begin
         n_fail++;
         $display("FAIL rr_grants: got g0=%0d g1=%0d, want 8 2", grants0, grants1);
      end
   endtask

   task automatic test_vc1_only();
      logic p0, p1;
      int   exp[8] = '{0, 2, 2, 2, 2, 2, 0, 0};
      logic [1:0] e;
      do_reset();
      occ1      = 5;
      active_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e = 2'(exp[i]);
         tick(p0, p1);
         n_cmp++;
         if ({p1, p0} !== e) begin
            n_fail++;
            $display("FAIL vc1_only_pop cycle %0d: got %b, want %b", i, {p1, p0}, e);
         end
      end
      n_cmp++;
      if (grants1 !== 8'd5 || grants0 !== 8'd0) begin
         n_fail++;
         $display("FAIL vc1_only_grants: got g0=%0d g1=%0d, want 0 5", grants0, grants1);
      end
   endtask

   task automatic test_dest_pause();
      logic p0, p1;
      int   exp[9] = '{0, 2, 2, 2, 2, 1, 1, 1, 2};
      logic [1:0] e;
      do_reset();
      occ0      = 4;
      occ1      = 6;
      vc0_dest  = 1'b1;
      vc1_dest  = 1'b0;
      pause_d1  = 1'b1;
      active_in = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i == 4) pause_d1 = 1'b0;
         e = 2'(exp[i]);
         tick(p0, p1);
         n_cmp++;
         if ({p1, p0} !== e) begin
            n_fail++;
            $display("FAIL dest_pause_pop cycle %0d: got %b, want %b", i, {p1, p0}, e);
         end
      end
   endtask

   task automatic test_pause_mid_burst();
      logic p0, p1;
      int   exp[6] = '{0, 1, 0, 0, 0, 1};
      logic [1:0] e;
      do_reset();
      occ0      = 8;
      active_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) pause_d0 = 1'b1;
         if (i == 4) pause_d0 = 1'b0;
         e = 2'(exp[i]);
         tick(p0, p1);
         n_cmp++;
         if ({p1, p0} !== e) begin
            n_fail++;
            $display("FAIL mid_pause_pop cycle %0d: got %b, want %b", i, {p1, p0}, e);
         end
      end
   endtask

   task automatic test_active();
      logic p0, p1;
      int   exp[6] = '{0, 0, 0, 0, 1, 1};
      logic [1:0] e;
      do_reset();
      occ0 = 8;
      occ1 = 8;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) active_in = 1'b1;
         e = 2'(exp[i]);
         tick(p0, p1);
         n_cmp++;
         if ({p1, p0} !== e) begin
            n_fail++;
            $display("FAIL active_pop cycle %0d: got %b, want %b", i, {p1, p0}, e);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic p0, p1;
      int   exp[5] = '{0, 2, 0, 0, 1};
      logic [1:0] e;
      do_reset();
      occ1      = 6;
      active_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            reset = 1'b1;
            occ0  = 8;
         end
         if (i == 3) reset = 1'b0;
         e = 2'(exp[i]);
         tick(p0, p1);
         n_cmp++;
         if ({p1, p0} !== e) begin
            n_fail++;
            $display("FAIL rst_burst_pop cycle %0d: got %b, want %b", i, {p1, p0}, e);
         end
         if (i == 1) begin
            n_cmp++;
            if (sel_vc !== 1'b1 || grants1 !== 8'd1) begin
               n_fail++;
               $display("FAIL rst_burst_pre: got sel=%b g1=%0d, want 1 1", sel_vc, grants1);
            end
         end
         if (i == 2) begin
            n_cmp++;
            if ({valid_vc1, valid_vc0, sel_vc, grants0, grants1} !== 19'd0) begin
               n_fail++;
               $display("FAIL rst_burst_clear: valid=%b%b sel=%b g0=%0d g1=%0d, want all 0",
                        valid_vc1, valid_vc0, sel_vc, grants0, grants1);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic p0, p1;
      int   pops;
      pops = 0;
      do_reset();
      occ0      = 300;
      active_in = 1'b1;
      for (int i = 0; i < 257; i++) begin
         tick(p0, p1);
         if (p0) pops++;
         if (p0 && pops == 255) begin
            n_cmp++;
            if (grants0 !== 8'd255) begin
               n_fail++;
               $display("FAIL wrap_255: got %0d, want 255", grants0);
            end
         end
      end
      n_cmp++;
      if (pops != 256) begin
         n_fail++;
         $display("FAIL wrap_pops: got %0d, want 256", pops);
      end
      n_cmp++;
      if (grants0 !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap_grants0: got %0d, want 0", grants0);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      occ0   = 0;
      occ1   = 0;
      reset  = 1'b1;
      active_in = 1'b0;
      vc0_dest  = 1'b0;
      vc1_dest  = 1'b0;
      pause_d0  = 1'b0;
      pause_d1  = 1'b0;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_vc1_only();
      test_dest_pause();
      test_pause_mid_burst();
      test_active();
      test_reset_mid_burst();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
